// File: rtl/cache_ctrl_2way.sv
// Controller for a 2-way, 4-set, 4-word-line write-back/write-allocate data cache.
// Hits complete in the lookup cycle; misses stall through optional write-back then line fill.
module cache_ctrl_2way #(
    parameter int ADDR_W = 30,
    parameter int TAG_W  = 26,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                proc_read,
    input  logic                proc_write,
    input  logic [ADDR_W-1:0]   proc_addr,
    input  logic [31:0]         proc_wdata,
    output logic                proc_stall,
    output logic [31:0]         proc_rdata,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [TAG_W+129:0]  sram_wdata,
    output logic                sram_write,
    input  logic [TAG_W+129:0]  sram_rdata,
    input  logic                sram_hit,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [127:0]        mem_wdata,
    input  logic [127:0]        mem_rdata,
    input  logic                mem_ready,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    localparam int ENT_W = TAG_W + 130;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TAG_W-1:0]   victim_tag;
    logic [127:0]       victim_data;
    logic               refill;
    logic               req;
    logic               count_hit;
    logic               count_miss;
    logic               latch_victim;
    logic               fill_done;
    logic [1:0]         offset;
    logic [1:0]         index;
    logic [TAG_W-1:0]   tag;

    assign req       = proc_read | proc_write;
    assign offset    = proc_addr[1:0];
    assign index     = proc_addr[3:2];
    assign tag       = proc_addr[ADDR_W-1:4];
    assign sram_addr = proc_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            victim_tag  <= '0;
            victim_data <= '0;
            refill      <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            state  <= state_nxt;
            // The first IDLE cycle after a fill is a re-lookup, not a fresh hit.
            refill <= fill_done;
            if (latch_victim) begin
                victim_tag  <= sram_rdata[ENT_W-3:128];
                victim_data <= sram_rdata[127:0];
            end
            if (count_hit && (hit_cnt != {CNT_W{1'b1}})) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (count_miss && (miss_cnt != {CNT_W{1'b1}})) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        proc_stall   = 1'b0;
        proc_rdata   = '0;
        sram_write   = 1'b0;
        sram_wdata   = sram_rdata;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        count_hit    = 1'b0;
        count_miss   = 1'b0;
        latch_victim = 1'b0;
        fill_done    = 1'b0;

        case (state)
            IDLE: begin
                proc_rdata = sram_rdata[{offset, 5'b0} +: 32];
                if (req) begin
                    if (sram_hit) begin
                        count_hit = ~refill;
                        if (proc_write) begin
                            sram_write                      = 1'b1;
                            sram_wdata[{offset, 5'b0} +: 32] = proc_wdata;
                            sram_wdata[ENT_W-2]             = 1'b1;
                        end
                    end else begin
                        proc_stall   = 1'b1;
                        count_miss   = 1'b1;
                        latch_victim = 1'b1;
                        if (sram_rdata[ENT_W-1] && sram_rdata[ENT_W-2]) begin
                            state_nxt = WRITEBACK;
                        end else begin
                            state_nxt = ALLOCATE;
                        end
                    end
                end
            end

            WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {victim_tag, index};
                mem_wdata  = victim_data;
                if (mem_ready) begin
                    state_nxt = ALLOCATE;
                end
            end

            ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = proc_addr[ADDR_W-1:2];
                // Lookup still misses here, so the array places the line in its LRU way.
                if (mem_ready) begin
                    sram_write = 1'b1;
                    sram_wdata = {1'b1, 1'b0, tag, mem_rdata};
                    fill_done  = 1'b1;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Randomized bench for cache_ctrl_2way: behavioural SRAM array and main memory around the DUT,
// with an architectural word store and per-set recency lists predicting data, latency and counters.
module tb_cache_ctrl_2way;

    logic         clk = 1'b0;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic [29:0]  sram_addr;
    logic [155:0] sram_wdata;
    logic         sram_write;
    logic [155:0] sram_rdata;
    logic         sram_hit;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl_2way #(.ADDR_W(30), .TAG_W(26), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_write (sram_write),
        .sram_rdata (sram_rdata),
        .sram_hit   (sram_hit),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // SRAM array: hit way, else LRU victim; a write lands in that way and makes the other way LRU.
    logic [155:0] sram_ent [4][2];
    logic         sram_lru [4];
    logic [1:0]   s_idx;
    logic         s_h0, s_h1, s_way;

    always_comb begin
        s_idx      = sram_addr[3:2];
        s_h0       = sram_ent[s_idx][0][155] && (sram_ent[s_idx][0][153:128] == sram_addr[29:4]);
        s_h1       = sram_ent[s_idx][1][155] && (sram_ent[s_idx][1][153:128] == sram_addr[29:4]);
        sram_hit   = s_h0 | s_h1;
        s_way      = s_h0 ? 1'b0 : (s_h1 ? 1'b1 : sram_lru[s_idx]);
        sram_rdata = sram_ent[s_idx][s_way];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) begin
                sram_ent[s][0] <= '0;
                sram_ent[s][1] <= '0;
                sram_lru[s]    <= 1'b0;
            end
        end else if (sram_write) begin
            sram_ent[s_idx][s_way] <= sram_wdata;
            sram_lru[s_idx]        <= ~s_way;
        end
    end

    // Main memory and reference model (word-addressed, tags kept small).
    logic [31:0] mm       [128];
    logic [31:0] ref_word [128];
    int          set_q    [4][$];
    bit          line_dirty [32];
    int          exp_hit;
    int          exp_miss;

    task automatic model_reset();
        for (int s = 0; s < 4; s++) set_q[s].delete();
        for (int l = 0; l < 32; l++) line_dirty[l] = 1'b0;
        for (int a = 0; a < 128; a++) ref_word[a] = mm[a];
        exp_hit  = 0;
        exp_miss = 0;
    endtask

    task automatic do_access(input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                             input int wb_wait, input int fill_wait);
        int           set, tag, pos, vtag, stalls, wb_cnt, fill_cnt, exp_stall;
        bit           hit, vdirty, done;
        logic [127:0] vline;
        logic [6:0]   wa;
        set  = int'(addr[3:2]);
        tag  = int'(addr[29:4]);
        pos  = -1;
        for (int i = 0; i < set_q[set].size(); i++) if (set_q[set][i] == tag) pos = i;
        hit    = (pos >= 0);
        vdirty = 1'b0;
        vtag   = 0;
        vline  = '0;
        if (!hit && set_q[set].size() == 2) begin
            vtag   = set_q[set][1];
            vdirty = line_dirty[vtag*4 + set];
            for (int k = 0; k < 4; k++) vline[32*k +: 32] = ref_word[vtag*16 + set*4 + k];
        end

        proc_read  = ~wr;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        stalls = 0; wb_cnt = 0; fill_cnt = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            mem_ready = 1'b0;
            if (mem_write) begin
                wb_cnt++;
                if (wb_cnt == 1) begin
                    check("wb_addr", 128'(mem_addr), 128'({vtag[25:0], addr[3:2]}));
                    check("wb_data", mem_wdata, vline);
                    check("rdata_busy", 128'(proc_rdata), 128'(0));
                    check("rd_wr_excl", 128'(mem_read), 128'(0));
                end
                if (wb_cnt == wb_wait) begin
                    mem_ready = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        wa = {mem_addr[4:0], 2'(k)};
                        mm[wa] = mem_wdata[32*k +: 32];
                    end
                end
            end else if (mem_read) begin
                fill_cnt++;
                if (fill_cnt == 1) check("fill_addr", 128'(mem_addr), 128'(addr[29:2]));
                if (fill_cnt == fill_wait) begin
                    mem_ready = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        wa = {mem_addr[4:0], 2'(k)};
                        mem_rdata[32*k +: 32] = mm[wa];
                    end
                end
            end
            #1;
            if (mem_ready && mem_read) begin
                check("fill_write", 128'(sram_write), 128'(1));
                check("fill_vd", 128'(sram_wdata[155:154]), 128'(2'b10));
            end else if (proc_stall) begin
                check("no_sram_wr", 128'(sram_write), 128'(0));
            end
            if (!proc_stall) begin
                done = 1'b1;
                check("idle_mem", 128'({mem_read, mem_write}), 128'(0));
                if (wr) begin
                    check("wr_strobe", 128'(sram_write), 128'(1));
                    check("wr_dirty", 128'(sram_wdata[154]), 128'(1));
                    check("wr_word", 128'(sram_wdata[{addr[1:0], 5'b0} +: 32]), 128'(wd));
                end else begin
                    check("rdata", 128'(proc_rdata), 128'(ref_word[addr[6:0]]));
                end
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("timeout", 128'(0), 128'(1));
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;

        if (!hit) begin
            if (set_q[set].size() == 2) void'(set_q[set].pop_back());
            set_q[set].push_front(tag);
            line_dirty[tag*4 + set] = 1'b0;
            if (exp_miss < 65535) exp_miss++;
        end else begin
            if (exp_hit < 65535) exp_hit++;
        end
        if (wr) begin
            ref_word[addr[6:0]]     = wd;
            line_dirty[tag*4 + set] = 1'b1;
            if (hit) begin
                set_q[set].delete(pos);
                set_q[set].push_front(tag);
            end
        end
        exp_stall = hit ? 0 : (vdirty ? wb_wait + fill_wait + 1 : fill_wait + 1);
        check("stall_cycles", 128'(stalls), 128'(exp_stall));
        check("wb_cycles", 128'(wb_cnt), 128'(vdirty ? wb_wait : 0));
        check("hit_cnt", 128'(hit_cnt), 128'(exp_hit));
        check("miss_cnt", 128'(miss_cnt), 128'(exp_miss));
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        for (int a = 0; a < 128; a++) mm[a] = 32'hC0DE_0000 | 32'(a);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_stall", 128'(proc_stall), 128'(0));
        check("rst_mem", 128'({mem_read, mem_write}), 128'(0));
        check("rst_sram_wr", 128'(sram_write), 128'(0));
        check("rst_hit", 128'(hit_cnt), 128'(0));
        check("rst_miss", 128'(miss_cnt), 128'(0));

        do_access(1'b0, 30'h10, 32'h0, 1, 3);          // cold read
        do_access(1'b0, 30'h11, 32'h0, 1, 1);          // hit
        do_access(1'b1, 30'h12, 32'hDEADBEEF, 1, 1);   // write hit
        do_access(1'b0, 30'h12, 32'h0, 1, 1);
        do_access(1'b0, 30'h20, 32'h0, 1, 2);          // second way of index 0
        do_access(1'b0, 30'h31, 32'h0, 2, 3);          // dirty victim: write-back then fill
        do_access(1'b0, 30'h23, 32'h0, 1, 1);          // other way untouched
        do_access(1'b0, 30'h12, 32'h0, 3, 2);          // clean victim: fill only

        for (int i = 0; i < 160; i++) begin
            do_access(1'($urandom_range(0, 1)), 30'($urandom_range(0, 95)), $urandom,
                      int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
        end

        // Reset in the middle of a write-back.
        do_reset();
        do_access(1'b1, 30'h14, 32'h1234_5678, 1, 1);
        do_access(1'b0, 30'h24, 32'h0, 1, 1);
        proc_read = 1'b1;
        proc_addr = 30'h34;
        for (int c = 0; c < 20 && !mem_write; c++) begin
            @(posedge clk);
            #1;
        end
        check("wb_started", 128'(mem_write), 128'(1));
        rst       = 1'b1;
        proc_read = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_wr", 128'(mem_write), 128'(0));
        check("rst_mid_rd", 128'(mem_read), 128'(0));
        check("rst_mid_stall", 128'(proc_stall), 128'(0));
        check("rst_mid_hit", 128'(hit_cnt), 128'(0));
        check("rst_mid_miss", 128'(miss_cnt), 128'(0));
        rst = 1'b0;
        model_reset();
        do_access(1'b0, 30'h34, 32'h0, 1, 2);
        do_access(1'b0, 30'h14, 32'h0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
